// File: rtl/hd_burst_tx_pkg.sv
// Shared definitions for the burst transmitter: state encoding.
package hd_burst_tx_pkg;

    // IDLE waits for a command, SEND presents a word, GAP idles between words,
    // DONE emits the completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hd_burst_tx.sv
// Burst transmitter: takes a {base, stride, len, gap} command and emits len words
// base, base+stride, ... on a valid/ready stream. An optional idle gap follows each
// non-final word. All stream outputs are registered, so valid never depends on ready.
module hd_burst_tx
    import hd_burst_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_base,
    input  logic [DATA_WIDTH-1:0] cmd_stride,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [GAP_WIDTH-1:0]  cmd_gap,
    input  logic                  ready,
    output logic                  valid_output,
    output logic [DATA_WIDTH-1:0] data_dest,
    output logic                  last_output,
    output logic                  done,
    output logic                  busy
);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] stride_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    // Words still to be transferred, counting the one currently presented.
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  accept;
    logic                  xfer;
    logic                  final_word;

    assign cmd_ready  = (state == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    // valid_output is only ever set in SEND, so xfer implies state == SEND.
    assign xfer       = valid_output && ready;
    assign final_word = (remaining == LEN_WIDTH'(1));

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (final_word) begin
                        state_nxt = DONE;
                    end else if (gap_q != '0) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_WIDTH'(1)) begin
                    state_nxt = SEND;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs; a reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_output <= 1'b0;
            last_output  <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            data_dest    <= '0;
            stride_q     <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            remaining    <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        stride_q     <= cmd_stride;
                        gap_q        <= cmd_gap;
                        remaining    <= cmd_len;
                        data_dest    <= cmd_base;
                        valid_output <= (cmd_len != '0);
                        last_output  <= (cmd_len == LEN_WIDTH'(1));
                    end
                end
                SEND: begin
                    if (xfer) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        data_dest <= data_dest + stride_q;
                        if (final_word) begin
                            valid_output <= 1'b0;
                            last_output  <= 1'b0;
                        end else if (gap_q == '0) begin
                            last_output <= (remaining == LEN_WIDTH'(2));
                        end else begin
                            valid_output <= 1'b0;
                            last_output  <= 1'b0;
                            gap_cnt      <= gap_q;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_WIDTH'(1)) begin
                        gap_cnt      <= '0;
                        valid_output <= 1'b1;
                        last_output  <= final_word;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_burst_tx.sv
// Directed bench for hd_burst_tx: table of burst commands with hand-computed
// word counts, final data, done timing and valid patterns, plus reset sequences.
module tb_hd_burst_tx;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_base;
    logic [DW-1:0] cmd_stride;
    logic [LW-1:0] cmd_len;
    logic [GW-1:0] cmd_gap;
    logic          ready;
    logic          valid_output;
    logic [DW-1:0] data_dest;
    logic          last_output;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    hd_burst_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride),
        .cmd_len(cmd_len), .cmd_gap(cmd_gap),
        .ready(ready), .valid_output(valid_output),
        .data_dest(data_dest), .last_output(last_output),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] base;
        logic [DW-1:0] stride;
        logic [LW-1:0] len;
        logic [GW-1:0] gap;
        logic [31:0]   rdy;        // bit c = ready during burst cycle c
        int            exp_words;
        logic [DW-1:0] exp_last;   // data of the final transferred word
        int            exp_done_c; // burst cycle in which done is seen
        logic [31:0]   exp_vpat;   // bit c = valid_output in burst cycle c
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int            k;
        int            done_c;
        bit            got_done;
        logic [31:0]   vpat;
        logic [DW-1:0] last_data;
        logic [DW-1:0] exp_data;
        logic          pv;
        logic          pr;
        logic          pl;
        logic [DW-1:0] pd;
        @(negedge clk);
        check($sformatf("v%0d cmd_ready_idle", idx), 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_base   = v.base;
        cmd_stride = v.stride;
        cmd_len    = v.len;
        cmd_gap    = v.gap;
        ready      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Garbage command held valid during the burst must never be taken.
        cmd_base   = 32'hDEAD_BEEF;
        cmd_stride = 32'h0000_0100;
        cmd_len    = 8'd7;
        cmd_gap    = 4'd3;
        k = 0; done_c = -1; got_done = 1'b0; vpat = '0; last_data = '0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int c = 1; c <= 400 && !got_done; c++) begin
            if (c > 1) @(negedge clk);
            if (c < 32 && valid_output) vpat[c] = 1'b1;
            check($sformatf("v%0d c%0d cmd_ready_busy", idx, c), 64'(cmd_ready), 64'd0);
            check($sformatf("v%0d c%0d busy", idx, c), 64'(busy), 64'd1);
            if (pv && !pr) begin
                check($sformatf("v%0d c%0d stall_valid", idx, c), 64'(valid_output), 64'd1);
                check($sformatf("v%0d c%0d stall_data", idx, c), 64'(data_dest), 64'(pd));
                check($sformatf("v%0d c%0d stall_last", idx, c), 64'(last_output), 64'(pl));
            end
            if (valid_output) begin
                exp_data = v.base + v.stride * 32'(k);
                check($sformatf("v%0d w%0d data", idx, k), 64'(data_dest), 64'(exp_data));
                check($sformatf("v%0d w%0d last", idx, k), 64'(last_output),
                      64'(k == int'(v.len) - 1));
            end
            if (done) begin
                got_done = 1'b1;
                done_c   = c;
                check($sformatf("v%0d done_no_valid", idx), 64'(valid_output), 64'd0);
            end
            ready = (c < 32) ? v.rdy[c] : 1'b1;
            if (valid_output && ready) begin
                last_data = data_dest;
                k++;
            end
            pv = valid_output; pr = ready; pl = last_output; pd = data_dest;
            cmd_valid = !got_done;
        end
        cmd_valid = 1'b0;
        check($sformatf("v%0d words", idx), 64'(k), 64'(v.exp_words));
        check($sformatf("v%0d last_data", idx), 64'(last_data), 64'(v.exp_last));
        check($sformatf("v%0d done_cycle", idx), 64'(done_c), 64'(v.exp_done_c));
        check($sformatf("v%0d valid_pattern", idx), 64'(vpat), 64'(v.exp_vpat));
        @(negedge clk);
        check($sformatf("v%0d done_pulse_end", idx), 64'(done), 64'd0);
        check($sformatf("v%0d busy_end", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d cmd_ready_back", idx), 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        vecs[0] = '{32'h10, 32'h4, 8'd4, 4'd0, 32'hFFFF_FFFF, 4, 32'h1C, 5, 32'h1E};
        vecs[1] = '{32'h10, 32'h4, 8'd4, 4'd0, 32'hFFFF_FFE3, 4, 32'h1C, 8, 32'hFE};
        vecs[2] = '{32'h100, 32'h8, 8'd3, 4'd2, 32'hFFFF_FFFF, 3, 32'h110, 8, 32'h92};
        vecs[3] = '{32'h55, 32'h1, 8'd0, 4'd0, 32'hFFFF_FFFF, 0, 32'h0, 1, 32'h0};
        vecs[4] = '{32'hFFFF_FFFE, 32'h1, 8'd3, 4'd0, 32'hFFFF_FFFF, 3, 32'h0, 4, 32'hE};
        vecs[5] = '{32'h7, 32'h3, 8'd1, 4'd5, 32'hFFFF_FFFF, 1, 32'h7, 2, 32'h2};
        vecs[6] = '{32'h20, 32'hFFFF_FFFF, 8'd2, 4'd1, 32'hFFFF_FFFD, 2, 32'h1F, 5, 32'h16};
        vecs[7] = '{32'h0, 32'h1, 8'd255, 4'd0, 32'hFFFF_FFFF, 255, 32'hFE, 256, 32'hFFFF_FFFE};
        vecs[8] = '{32'h9, 32'h10, 8'd2, 4'd15, 32'hFFFF_FFFF, 2, 32'h19, 18, 32'h0002_0002};

        rst = 1'b1; cmd_valid = 1'b1; cmd_base = 32'hAAAA_0000; cmd_stride = 32'h1;
        cmd_len = 8'd5; cmd_gap = 4'd0; ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst valid", 64'(valid_output), 64'd0);
        check("rst last", 64'(last_output), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst data", 64'(data_dest), 64'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset after two of eight words have transferred.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_base = 32'h1000; cmd_stride = 32'h2;
        cmd_len = 8'd8; cmd_gap = 4'd0; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst third_word", 64'(data_dest), 64'h1004);
        check("midrst third_valid", 64'(valid_output), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst valid", 64'(valid_output), 64'd0);
        check("midrst data", 64'(data_dest), 64'd0);
        check("midrst last", 64'(last_output), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst cmd_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("postrst c%0d valid", c), 64'(valid_output), 64'd0);
            check($sformatf("postrst c%0d done", c), 64'(done), 64'd0);
            check($sformatf("postrst c%0d busy", c), 64'(busy), 64'd0);
        end
        run_vec(9, vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
